// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for an NDIGITS seven-segment display
//   that shares a single sevenseg decoder. Each digit gets a DIV-cycle slot:
//   the first cycle of a slot is a blank gap, which suppresses ghosting, and
//   the remaining cycles show the digit. New values are double-buffered and
//   swapped in only at frame boundaries, so a frame never mixes old and new
//   digits.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   load         single-cycle strobe that captures value
//   value        packed BCD digits, digit k = value[4k+3:4k]
//   lzb          leading-zero blanking enable (live)
//   data         4-bit code to the shared decoder; 4'hF = blank
//   dig_en       one-hot digit enable; all-zero during gaps
//   frame_start  high on the first cycle of each frame
//   pend         a loaded value is waiting for the next frame boundary
module sevenseg_scan_ctrl #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   lzb,
    output logic [3:0]             data,
    output logic [NDIGITS-1:0]     dig_en,
    output logic                   frame_start,
    output logic                   pend
);
    localparam int IW = $clog2(NDIGITS);
    localparam int CW = $clog2(DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [IW-1:0]          idx;
    logic [CW-1:0]          cnt;
    logic [4*NDIGITS-1:0]   act;
    logic [4*NDIGITS-1:0]   shd;
    logic                   slot_end;
    logic                   swap;

    assign slot_end = (cnt == CNT_LAST);
    // Last cycle of the frame: the only edge on which act may change.
    assign swap     = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            cnt  <= '0;
            act  <= '0;
            shd  <= '0;
            pend <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (swap) begin
                // A load landing on the swap edge bypasses the shadow so it
                // shows in the very next frame instead of one frame later.
                pend <= 1'b0;
                if (load)
                    act <= value;
                else if (pend)
                    act <= shd;
            end else if (load) begin
                shd  <= value;
                pend <= 1'b1;
            end
        end
    end

    // Leading-zero blanking. zhi[k] is set when digit k and every digit
    // above it are zero; digit 0 is never blanked so "0" stays visible.
    logic [NDIGITS-1:1] zhi;
    logic [3:0]         dig [NDIGITS];

    genvar k;
    generate
        for (k = 0; k < NDIGITS; k++) begin : g_dig
            if (k == 0) begin : g_lsd
                assign dig[k] = act[3:0];
            end else begin : g_hi
                if (k == NDIGITS - 1) begin : g_top
                    assign zhi[k] = (act[4*k +: 4] == 4'h0);
                end else begin : g_mid
                    assign zhi[k] = (act[4*k +: 4] == 4'h0) && zhi[k+1];
                end
                assign dig[k] = (lzb && zhi[k]) ? 4'hF : act[4*k +: 4];
            end
        end
    endgenerate

    // Moore decode: outputs depend only on registered state (plus live lzb).
    always_comb begin
        dig_en = '0;
        data   = 4'hF;
        if (cnt != '0) begin
            dig_en = NDIGITS'(1) << idx;
            data   = dig[idx];
        end
    end

    assign frame_start = (idx == '0) && (cnt == '0);

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NDIGITS=4, DIV=4 (16-cycle
// frame). A per-cycle vector table covers scanning, deferred and swap-edge
// loads and blanking; hand sequences cover async reset mid-frame and a
// random-load run watching the dig_en invariants.
module tb_sevenseg_scan_ctrl;
    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        lzb;
    logic [3:0]  data;
    logic [3:0]  dig_en;
    logic        frame_start;
    logic        pend;

    int tests = 0;
    int fails = 0;

    sevenseg_scan_ctrl #(.NDIGITS(4), .DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .lzb         (lzb),
        .data        (data),
        .dig_en      (dig_en),
        .frame_start (frame_start),
        .pend        (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic        lz;
        logic [3:0]  en;
        logic [3:0]  dat;
        logic        fs;
        logic        pd;
    } vec_t;

    vec_t tv [128];

    // One frame of rows; shown holds the hand-written expected nibble per
    // digit (digit k in shown[4k+3:4k]).
    task automatic add_frame(input int base, input logic [15:0] shown,
                             input logic lz);
        for (int c = 0; c < 16; c++) begin
            tv[base+c].ld  = 1'b0;
            tv[base+c].val = 16'h0000;
            tv[base+c].lz  = lz;
            tv[base+c].fs  = (c == 0);
            tv[base+c].pd  = 1'b0;
            if (c % 4 == 0) begin
                tv[base+c].en  = 4'b0000;
                tv[base+c].dat = 4'hF;
            end else begin
                tv[base+c].en  = 4'b0001 << (c / 4);
                tv[base+c].dat = shown[4*(c/4) +: 4];
            end
        end
    endtask

    task automatic add_load(input int cyc, input logic [15:0] v);
        tv[cyc].ld  = 1'b1;
        tv[cyc].val = v;
    endtask

    task automatic set_pend(input int from, input int to);
        for (int i = from; i <= to; i++) tv[i].pd = 1'b1;
    endtask

    task automatic chk(input string nm, input int cyc,
                       input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    initial begin
        logic [3:0] prev;

        // Frames 0-1: idle scan of act=0. Load at 21 waits for the swap.
        add_frame(0,   16'h0000, 1'b0);
        add_frame(16,  16'h0000, 1'b0);
        add_load(21, 16'h1234);
        set_pend(22, 31);
        // Frame 2: 1234 shown; two loads, newest wins.
        add_frame(32,  16'h1234, 1'b0);
        add_load(35, 16'h1111);
        add_load(41, 16'h2222);
        set_pend(36, 47);
        // Frame 3: 2222; load exactly on the swap edge (frame cycle 15).
        add_frame(48,  16'h2222, 1'b0);
        add_load(63, 16'h5678);
        // Frame 4: 5678 straight away, pend never rises.
        add_frame(64,  16'h5678, 1'b0);
        add_load(79, 16'h0070);
        // Frame 5: act=0070 with lzb -> 0,7,F,F.
        add_frame(80,  16'hFF70, 1'b1);
        add_load(95, 16'h0000);
        // Frame 6: act=0000 with lzb -> 0,F,F,F; frame 7 lzb off -> all 0.
        add_frame(96,  16'hFFF0, 1'b1);
        add_frame(112, 16'h0000, 1'b0);

        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        lzb   = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_en",   -1, 16'(dig_en),      16'h0);
        chk("rst_data", -1, 16'(data),        16'hF);
        chk("rst_fs",   -1, 16'(frame_start), 16'h1);
        chk("rst_pend", -1, 16'(pend),        16'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            load  = tv[i].ld;
            value = tv[i].val;
            lzb   = tv[i].lz;
            #1;
            chk("dig_en",      i, 16'(dig_en),      16'(tv[i].en));
            chk("data",        i, 16'(data),        16'(tv[i].dat));
            chk("frame_start", i, 16'(frame_start), 16'(tv[i].fs));
            chk("pend",        i, 16'(pend),        16'(tv[i].pd));
        end

        // Make act nonzero (8888) via a swap-edge load at cycle 143.
        lzb = 1'b0;
        for (int c = 128; c < 144; c++) begin
            @(negedge clk);
            load  = (c == 143);
            value = 16'h8888;
        end
        // Next frame: load 9999 at frame cycle 2, stop at frame cycle 10.
        for (int fc = 0; fc <= 10; fc++) begin
            @(negedge clk);
            load  = (fc == 2);
            value = 16'h9999;
        end
        #1;
        chk("mid_pend", 154, 16'(pend),   16'h1);
        chk("mid_data", 154, 16'(data),   16'h8);
        chk("mid_en",   154, 16'(dig_en), 16'h4);
        load = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_en",   154, 16'(dig_en),      16'h0);
        chk("arst_data", 154, 16'(data),        16'hF);
        chk("arst_pend", 154, 16'(pend),        16'h0);
        chk("arst_fs",   154, 16'(frame_start), 16'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_gap_en", 0, 16'(dig_en),      16'h0);
        chk("rel_gap_fs", 0, 16'(frame_start), 16'h1);
        @(negedge clk);
        #1;
        chk("rel_en",   1, 16'(dig_en),      16'h1);
        chk("rel_data", 1, 16'(data),        16'h0);
        chk("rel_fs",   1, 16'(frame_start), 16'h0);
        // Pending 9999 was dropped by reset: next frame still shows 0.
        repeat (16) @(negedge clk);
        #1;
        chk("rel_nf_pend", 17, 16'(pend),   16'h0);
        chk("rel_nf_en",   17, 16'(dig_en), 16'h1);
        chk("rel_nf_data", 17, 16'(data),   16'h0);

        // Random loads: dig_en zero/one-hot, and never digit-to-digit.
        prev = 4'b0000;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            lzb   = 1'($urandom);
            #1;
            tests++;
            if (!$onehot0(dig_en) ||
                (prev != 4'b0000 && dig_en != 4'b0000 && dig_en != prev)) begin
                fails++;
                $display("FAIL inv_dig_en n=%0d got=%b prev=%b expected onehot0, no direct change",
                         n, dig_en, prev);
            end
            prev = dig_en;
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
